// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave read-path controller.
// Holds the FSM state encoding, the SDA selector codes and the state-to-selector mapping.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_ADDR   = 4'd1,
    ACK_WAIT  = 4'd2,
    NACK_WAIT = 4'd3,
    DRV_ACK   = 4'd4,
    DRV_NACK  = 4'd5,
    LOAD      = 4'd6,
    TX_BIT    = 4'd7,
    MACK      = 4'd8,
    MACK_DONE = 4'd9
  } state_t;

  localparam logic [1:0] SDA_IDLE = 2'b00;
  localparam logic [1:0] SDA_ACK  = 2'b01;
  localparam logic [1:0] SDA_NACK = 2'b10;
  localparam logic [1:0] SDA_TX   = 2'b11;

  localparam logic [6:0] DEF_SLV_ADDR = 7'b1111000;

  // LOAD keeps SDA released so the stale shift register never reaches the bus.
  function automatic logic [1:0] sda_mode_of(input state_t s);
    logic [1:0] m;
    m = SDA_IDLE;
    case (s)
      DRV_ACK:  m = SDA_ACK;
      DRV_NACK: m = SDA_NACK;
      TX_BIT:   m = SDA_TX;
      default:  m = SDA_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tx_sr.sv
// 8-bit transmit shift register: parallel load, shift left with 1-fill, MSB drives tx_out.
// Load has priority over shift; both strobes come from the controller FSM.
module tx_sr (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_data,
  output logic       tx_out
);

  logic [7:0] sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= 8'hFF;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {sr[6:0], 1'b1};
    end
  end

  assign tx_out = sr[7];

endmodule

// File: rtl/i2c_tx_ctrl.sv
// I2C slave read-path controller: matches the address after START, drives ACK/NACK,
// shifts TX FIFO bytes out MSB-first and samples the master's ACK after each byte.
module i2c_tx_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = DEF_SLV_ADDR
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       byte_received,
  input  logic [7:0] rx_data,
  input  logic       sda_in,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic [1:0] sda_mode,
  output logic       tx_out,
  output logic       rx_enable,
  output logic       tx_read,
  output state_t     state_dbg
);

  state_t     state;
  state_t     next_state;
  logic [2:0] bit_cnt;
  logic       addr_hit;
  logic       sr_load;
  logic       sr_shift;
  logic [7:0] sr_data;

  assign addr_hit  = (rx_data[7:1] == SLV_ADDR) && rx_data[0];
  assign state_dbg = state;

  // STOP beats START, and both beat every state-local transition.
  always_comb begin
    next_state = state;
    if (stop_found) begin
      next_state = IDLE;
    end else if (start_found) begin
      next_state = RX_ADDR;
    end else begin
      case (state)
        IDLE:      next_state = IDLE;
        RX_ADDR:   if (byte_received) next_state = addr_hit ? ACK_WAIT : NACK_WAIT;
        ACK_WAIT:  if (scl_fall) next_state = DRV_ACK;
        NACK_WAIT: if (scl_fall) next_state = DRV_NACK;
        DRV_ACK:   if (scl_fall) next_state = LOAD;
        DRV_NACK:  if (scl_fall) next_state = IDLE;
        LOAD:      next_state = TX_BIT;
        TX_BIT:    if (scl_fall && (bit_cnt == 3'd7)) next_state = MACK;
        MACK:      if (scl_rise) next_state = sda_in ? IDLE : MACK_DONE;
        MACK_DONE: if (scl_fall) next_state = LOAD;
        default:   next_state = IDLE;
      endcase
    end
  end

  // FIFO pop contract: tx_read is a single-cycle pulse, high only while in LOAD and only
  // when the FIFO was non-empty; the byte popped is exactly the one loaded into the shifter.
  assign sr_load  = (state == LOAD);
  assign sr_data  = tx_read ? tx_data : 8'hFF;
  assign sr_shift = (state == TX_BIT) && (next_state == TX_BIT) && scl_fall;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      sda_mode  <= SDA_IDLE;
      rx_enable <= 1'b0;
      tx_read   <= 1'b0;
      bit_cnt   <= 3'd0;
    end else begin
      state     <= next_state;
      sda_mode  <= sda_mode_of(next_state);
      rx_enable <= (next_state == RX_ADDR);
      tx_read   <= (next_state == LOAD) && !tx_empty;
      if (sr_load) begin
        bit_cnt <= 3'd0;
      end else if (sr_shift) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  tx_sr u_tx_sr (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (sr_load),
    .shift     (sr_shift),
    .load_data (sr_data),
    .tx_out    (tx_out)
  );

endmodule
